// File: rtl/mac_operand_sequencer_if.sv
// Operand-load, start/status, MAC-drive and result handshake signals of the MAC operand sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding logic, including the MAC.
interface mac_operand_sequencer_if #(
    parameter int unsigned AW = 2
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_ai;
    logic [7:0]    wr_xi;
    logic          start;
    logic [AW:0]   num_terms;
    logic          busy;
    logic [7:0]    mac_ai;
    logic [7:0]    mac_xi;
    logic          mac_last;
    logic [15:0]   mac_result;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_result;

    modport master (
        input  wr_en, wr_addr, wr_ai, wr_xi, start, num_terms, mac_result, out_ready,
        output busy, mac_ai, mac_xi, mac_last, out_valid, out_result
    );

    modport slave (
        output wr_en, wr_addr, wr_ai, wr_xi, start, num_terms, mac_result, out_ready,
        input  busy, mac_ai, mac_xi, mac_last, out_valid, out_result
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Streams buffered (ai, xi) term pairs into the product-sum MAC, marks the final term with mac_last,
// captures the MAC's combinational sum on that cycle and offers it on a valid/ready result port.
module mac_operand_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    mac_operand_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [AW:0]   n_terms;
    logic [AW:0]   num_clamped;
    logic          last_term;
    logic          wr_ok;
    logic [7:0]    buf_ai [DEPTH];
    logic [7:0]    buf_xi [DEPTH];

    assign num_clamped = (bus.num_terms > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_terms;
    assign last_term   = ({1'b0, idx} == n_terms - (AW+1)'(1));
    assign wr_ok       = bus.wr_en && (state == IDLE) && ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH));

    // Operand buffer: unreset storage, frozen whenever an evaluation is in flight
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            buf_ai[bus.wr_addr] <= bus.wr_ai;
            buf_xi[bus.wr_addr] <= bus.wr_xi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = (num_clamped == '0) ? HOLD : ISSUE;
            end
            ISSUE: begin
                if (last_term) state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MAC operands are zero whenever no term is issued, so an idle MAC accumulates nothing
    always_comb begin
        bus.busy      = 1'b0;
        bus.mac_ai    = 8'd0;
        bus.mac_xi    = 8'd0;
        bus.mac_last  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ISSUE: begin
                bus.busy     = 1'b1;
                bus.mac_ai   = buf_ai[idx];
                bus.mac_xi   = buf_xi[idx];
                bus.mac_last = last_term;
            end
            HOLD: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Term counter, latched term count and captured sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            n_terms        <= '0;
            bus.out_result <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx     <= '0;
                        n_terms <= num_clamped;
                        if (num_clamped == '0) bus.out_result <= 16'd0;
                    end
                end
                ISSUE: begin
                    idx <= idx + AW'(1);
                    if (last_term) bus.out_result <= bus.mac_result;
                end
                default: ;
            endcase
        end
    end
endmodule
